// File: rtl/freq_gate_ctrl.sv
// Gate-window controller for the four-digit BCD frequency counter: drives hab/limp,
// waits for ripple settling, then captures the counter digits into display registers.
module freq_gate_ctrl #(
    parameter int unsigned GATE_CYCLES   = 1000,
    parameter int unsigned CLR_CYCLES    = 2,
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic       clk_0,
    input  logic       reset,
    input  logic       start,
    input  logic       modo,
    input  logic       parar,
    input  logic [3:0] cont_3,
    input  logic [3:0] cont_2,
    input  logic [3:0] cont_1,
    input  logic [3:0] cont_0,
    output logic       hab,
    output logic       limp,
    output logic [3:0] disp_3,
    output logic [3:0] disp_2,
    output logic [3:0] disp_1,
    output logic [3:0] disp_0,
    output logic       valido,
    output logic       erro,
    output logic       ocupado
);

    localparam int unsigned MaxGc     = (GATE_CYCLES > CLR_CYCLES) ? GATE_CYCLES : CLR_CYCLES;
    localparam int unsigned MaxCycles = (MaxGc > SETTLE_CYCLES) ? MaxGc : SETTLE_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

    // The counter holds "cycles left after this one", so each phase loads N-1.
    localparam logic [CntW-1:0] ClrLoad    = CntW'(CLR_CYCLES - 1);
    localparam logic [CntW-1:0] GateLoad   = CntW'(GATE_CYCLES - 1);
    localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StGate,
        StSettle,
        StLatch
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            start_q;
    logic            start_rise;
    logic            capture;
    logic            bad_digit;

    logic            hab_q, limp_q, valido_q, erro_q, ocupado_q;
    logic [3:0]      disp_3_q, disp_2_q, disp_1_q, disp_0_q;

    assign start_rise = start & ~start_q;
    assign bad_digit  = (cont_3 > 4'd9) | (cont_2 > 4'd9) | (cont_1 > 4'd9) | (cont_0 > 4'd9);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (parar) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Continuous mode re-arms on a held start level, not just an edge.
                    if (start_rise || (modo && start)) begin
                        state_d = StClear;
                        cnt_d   = ClrLoad;
                    end
                end
                StClear: begin
                    if (cnt_q == '0) begin
                        state_d = StGate;
                        cnt_d   = GateLoad;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                StGate: begin
                    if (cnt_q == '0) begin
                        state_d = StSettle;
                        cnt_d   = SettleLoad;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                StSettle: begin
                    if (cnt_q == '0) begin
                        state_d = StLatch;
                        capture = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                StLatch: begin
                    if (modo) begin
                        state_d = StClear;
                        cnt_d   = ClrLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_0 or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start;
        end
    end

    // Moore outputs registered from the next state so they line up with state_q.
    always_ff @(posedge clk_0 or negedge reset) begin
        if (!reset) begin
            hab_q     <= 1'b0;
            limp_q    <= 1'b0;
            valido_q  <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            hab_q     <= (state_d == StGate);
            limp_q    <= (state_d == StClear);
            valido_q  <= (state_d == StLatch);
            ocupado_q <= (state_d != StIdle);
        end
    end

    always_ff @(posedge clk_0 or negedge reset) begin
        if (!reset) begin
            disp_3_q <= 4'd0;
            disp_2_q <= 4'd0;
            disp_1_q <= 4'd0;
            disp_0_q <= 4'd0;
            erro_q   <= 1'b0;
        end else if (capture) begin
            disp_3_q <= cont_3;
            disp_2_q <= cont_2;
            disp_1_q <= cont_1;
            disp_0_q <= cont_0;
            erro_q   <= bad_digit;
        end
    end

    assign hab     = hab_q;
    assign limp    = limp_q;
    assign valido  = valido_q;
    assign erro    = erro_q;
    assign ocupado = ocupado_q;
    assign disp_3  = disp_3_q;
    assign disp_2  = disp_2_q;
    assign disp_1  = disp_1_q;
    assign disp_0  = disp_0_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Directed bench for freq_gate_ctrl: stimulus pushes expected captures into a
// scoreboard, an independent monitor pops and checks them on every valido pulse.
module tb_freq_gate_ctrl;

    localparam int unsigned Gate   = 10;
    localparam int unsigned Clr    = 2;
    localparam int unsigned Settle = 3;
    // Drive at negedge c -> detection edge c+1 -> valido visible after edge c+1+Clr+Gate+Settle.
    localparam int unsigned Lat    = Clr + Gate + Settle + 1;

    logic       clk_0 = 1'b0;
    logic       rst_n;
    logic       start, modo, parar;
    logic [3:0] cont_3, cont_2, cont_1, cont_0;
    logic       hab, limp, valido, erro, ocupado;
    logic [3:0] disp_3, disp_2, disp_1, disp_0;

    typedef struct packed {
        logic [15:0] disp;
        logic        erro;
        logic [31:0] due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    freq_gate_ctrl #(
        .GATE_CYCLES   (Gate),
        .CLR_CYCLES    (Clr),
        .SETTLE_CYCLES (Settle)
    ) dut (
        .clk_0   (clk_0),
        .reset   (rst_n),
        .start   (start),
        .modo    (modo),
        .parar   (parar),
        .cont_3  (cont_3),
        .cont_2  (cont_2),
        .cont_1  (cont_1),
        .cont_0  (cont_0),
        .hab     (hab),
        .limp    (limp),
        .disp_3  (disp_3),
        .disp_2  (disp_2),
        .disp_1  (disp_1),
        .disp_0  (disp_0),
        .valido  (valido),
        .erro    (erro),
        .ocupado (ocupado)
    );

    always #5 clk_0 = ~clk_0;
    always @(posedge clk_0) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    endtask

    task automatic set_cont(input logic [15:0] v);
        {cont_3, cont_2, cont_1, cont_0} = v;
    endtask

    task automatic wait_cyc(input int unsigned t);
        while (cyc < t) @(negedge clk_0);
    endtask

    task automatic expect_capture(input logic [15:0] d, input logic e, input int unsigned due);
        exp_t x;
        x.disp = d;
        x.erro = e;
        x.due  = due;
        sb.push_back(x);
    endtask

    // Monitor: pops one expectation per valido pulse.
    always @(negedge clk_0) begin
        if (rst_n) begin
            check("hab_limp_exclusive", 32'(hab & limp), 32'd0);
            if (valido) begin
                if (sb.size() == 0) begin
                    check("valido_unexpected", 32'(valido), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("cap_disp", 32'({disp_3, disp_2, disp_1, disp_0}), 32'(mon_e.disp));
                    check("cap_erro", 32'(erro), 32'(mon_e.erro));
                    check("cap_cycle", cyc, mon_e.due);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1);
    end

    initial begin
        int unsigned c;
        logic [1:0]  want_hl;
        logic [15:0] vals [3];
        vals = '{16'h1234, 16'h5678, 16'h9012};

        rst_n = 1'b0; start = 1'b0; modo = 1'b0; parar = 1'b0;
        set_cont(16'h0000);
        repeat (3) @(negedge clk_0);
        check("rst_hab", 32'(hab), 32'd0);
        check("rst_limp", 32'(limp), 32'd0);
        check("rst_valido", 32'(valido), 32'd0);
        check("rst_erro", 32'(erro), 32'd0);
        check("rst_ocupado", 32'(ocupado), 32'd0);
        check("rst_disp", 32'({disp_3, disp_2, disp_1, disp_0}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk_0);

        // Single shot: limp 2 cycles, hab 10, settle 3, latch, idle.
        c = cyc;
        set_cont(16'h0427);
        start = 1'b1;
        expect_capture(16'h0427, 1'b0, c + Lat);
        for (int j = 1; j <= 17; j++) begin
            wait_cyc(c + j);
            if (j == 1) start = 1'b0;
            want_hl = (j <= 2) ? 2'b01 : (j <= 12) ? 2'b10 : 2'b00;
            check("s1_hab_limp", 32'({hab, limp}), 32'(want_hl));
        end
        check("s1_ocupado_after", 32'(ocupado), 32'd0);
        check("s1_disp_hold", 32'({disp_3, disp_2, disp_1, disp_0}), 32'h0427);

        // Continuous: back-to-back 16-cycle periods; modo dropped during third gate.
        @(negedge clk_0);
        c = cyc;
        modo = 1'b1;
        start = 1'b1;
        for (int n = 0; n < 3; n++) begin
            wait_cyc(c + 16 * n + 5);
            set_cont(vals[n]);
            expect_capture(vals[n], 1'b0, c + Lat + 16 * n);
            if (n == 2) begin
                wait_cyc(c + 38);
                modo = 1'b0;
            end
            wait_cyc(c + Lat + 16 * n + 1);
            if (n < 2) begin
                check("s2_limp_after_valido", 32'(limp), 32'd1);
            end else begin
                check("s2_ocupado_end", 32'(ocupado), 32'd0);
                check("s2_limp_end", 32'(limp), 32'd0);
            end
        end
        start = 1'b0;

        // Abort in the 5th gate cycle.
        repeat (2) @(negedge clk_0);
        c = cyc;
        set_cont(16'h3333);
        start = 1'b1;
        wait_cyc(c + 1);
        start = 1'b0;
        wait_cyc(c + 7);
        check("s3_hab_before", 32'(hab), 32'd1);
        parar = 1'b1;
        wait_cyc(c + 8);
        parar = 1'b0;
        check("s3_hab_after", 32'(hab), 32'd0);
        check("s3_ocupado_after", 32'(ocupado), 32'd0);
        check("s3_disp_kept", 32'({disp_3, disp_2, disp_1, disp_0}), 32'h9012);
        wait_cyc(c + 30);
        // parar beats a simultaneous start edge
        start = 1'b1;
        parar = 1'b1;
        @(negedge clk_0);
        check("s3_parar_wins", 32'(ocupado), 32'd0);
        start = 1'b0;
        parar = 1'b0;
        repeat (2) @(negedge clk_0);
        c = cyc;
        set_cont(16'h0815);
        start = 1'b1;
        expect_capture(16'h0815, 1'b0, c + Lat);
        wait_cyc(c + 1);
        start = 1'b0;
        wait_cyc(c + 20);

        // Non-BCD digit raises erro; next clean capture clears it.
        c = cyc;
        set_cont(16'h000C);
        start = 1'b1;
        expect_capture(16'h000C, 1'b1, c + Lat);
        wait_cyc(c + 1);
        start = 1'b0;
        wait_cyc(c + 24);
        check("s4_erro_hold", 32'(erro), 32'd1);
        c = cyc;
        set_cont(16'h9999);
        start = 1'b1;
        expect_capture(16'h9999, 1'b0, c + Lat);
        wait_cyc(c + 1);
        start = 1'b0;
        wait_cyc(c + 20);

        // Asynchronous reset in the middle of SETTLE.
        c = cyc;
        set_cont(16'h5555);
        start = 1'b1;
        wait_cyc(c + 1);
        start = 1'b0;
        wait_cyc(c + 14);
        check("s5_in_settle", 32'({ocupado, hab, limp}), 32'b100);
        #1 rst_n = 1'b0;
        #1;
        check("s5_async_ctrl", 32'({hab, limp, valido, erro, ocupado}), 32'd0);
        check("s5_async_disp", 32'({disp_3, disp_2, disp_1, disp_0}), 32'd0);
        @(negedge clk_0);
        c = cyc;
        rst_n = 1'b1;
        start = 1'b1;
        expect_capture(16'h5555, 1'b0, c + Lat);
        wait_cyc(c + 40);
        check("s5_single_only", 32'(ocupado), 32'd0);
        start = 1'b0;

        // Start toggling while busy in single shot: ignored, not queued.
        @(negedge clk_0);
        c = cyc;
        set_cont(16'h2468);
        start = 1'b1;
        expect_capture(16'h2468, 1'b0, c + Lat);
        for (int j = 1; j <= 17; j++) begin
            wait_cyc(c + j);
            start = (j <= 16) && (j % 2 == 0);
        end
        wait_cyc(c + 40);
        check("s6_idle_after", 32'(ocupado), 32'd0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
